mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback-select stage of the five-stage CPU. Captures the MEM-stage result each cycle and drives the register file write port (`we`, `rw`, `rd`), which commits on the following rising edge. Supports stall and flush from the hazard unit, suppresses writes to register 0, and keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register and writeback-select stage of the five-stage CPU.
// Captures the MEM-stage result on every rising edge and drives the register
// file write port (we, rw, rd). The register file commits that write on the
// following rising edge. Register 0 is never written. A free-running counter
// tracks retired instructions.
//
// Optional feature:
//   WB_SUBWORD_LOAD_EN - when defined, load data is extracted from the
//   registered memory word according to the registered load type
//   (LW/LB/LBU/LH/LHU, little-endian, byte offset from alu[1:0]).
//   When undefined, load data is the memory word unchanged and m_ltype
//   is ignored.
//
// Ports:
//   clk       rising-edge clock, shared with the register file
//   clrn      asynchronous active-low reset
//   stall     hold all WB-stage contents this edge
//   flush     load a bubble this edge (overrides stall)
//   m_valid   MEM stage holds a real instruction
//   m_wreg    instruction writes a register
//   m_m2reg   1 = write memory data, 0 = write ALU result
//   m_rn      destination register index
//   m_alu     ALU result / effective address
//   m_mo      data-memory read word
//   m_ltype   load type (used only with WB_SUBWORD_LOAD_EN)
//   wb_valid  WB stage holds a real instruction
//   we        register file write enable
//   rw        register file write index
//   rd        register file write data
//   retired   count of instructions that have left WB (wraps silently)
// -----------------------------------------------------------------------------
module mem_wb_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic        m_wreg,
  input  logic        m_m2reg,
  input  logic [4:0]  m_rn,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_mo,
  input  logic [2:0]  m_ltype,
  output logic        wb_valid,
  output logic        we,
  output logic [4:0]  rw,
  output logic [31:0] rd,
  output logic [31:0] retired
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic        valid_q,   valid_d;
  logic        wreg_q,    wreg_d;
  logic        m2reg_q,   m2reg_d;
  logic [4:0]  rn_q,      rn_d;
  logic [31:0] alu_q,     alu_d;
  logic [31:0] mo_q,      mo_d;
  logic [31:0] retired_q, retired_d;
`ifdef WB_SUBWORD_LOAD_EN
  logic [2:0]  ltype_q,   ltype_d;
`else
  // Port kept for interface compatibility; nothing consumes it in this build.
  logic        unused_ltype;
  assign unused_ltype = ^m_ltype;
`endif

  logic        load_fields;
  logic        retire;
  logic [31:0] load_data;

  // Fields load on flush as well as on a normal advance; only valid is forced
  // low by a flush, so the bubble's other fields are don't-care.
  assign load_fields = flush | ~stall;

  // The instruction currently in WB leaves on any edge that is not a pure
  // stall. A flush still lets it leave, so it is counted.
  assign retire = valid_q & (~stall | flush);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    valid_d   = valid_q;
    wreg_d    = wreg_q;
    m2reg_d   = m2reg_q;
    rn_d      = rn_q;
    alu_d     = alu_q;
    mo_d      = mo_q;
    retired_d = retired_q;
`ifdef WB_SUBWORD_LOAD_EN
    ltype_d   = ltype_q;
`endif

    if (load_fields) begin
      valid_d = flush ? 1'b0 : m_valid;
      wreg_d  = m_wreg;
      m2reg_d = m_m2reg;
      rn_d    = m_rn;
      alu_d   = m_alu;
      mo_d    = m_mo;
`ifdef WB_SUBWORD_LOAD_EN
      ltype_d = m_ltype;
`endif
    end

    if (retire) begin
      retired_d = retired_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q   <= 1'b0;
      wreg_q    <= 1'b0;
      m2reg_q   <= 1'b0;
      rn_q      <= 5'd0;
      alu_q     <= 32'd0;
      mo_q      <= 32'd0;
      retired_q <= 32'd0;
`ifdef WB_SUBWORD_LOAD_EN
      ltype_q   <= 3'd0;
`endif
    end else begin
      valid_q   <= valid_d;
      wreg_q    <= wreg_d;
      m2reg_q   <= m2reg_d;
      rn_q      <= rn_d;
      alu_q     <= alu_d;
      mo_q      <= mo_d;
      retired_q <= retired_d;
`ifdef WB_SUBWORD_LOAD_EN
      ltype_q   <= ltype_d;
`endif
    end
  end

`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'd0;
    case (alu_q[1:0])
      2'd0:    sel_byte = mo_q[7:0];
      2'd1:    sel_byte = mo_q[15:8];
      2'd2:    sel_byte = mo_q[23:16];
      default: sel_byte = mo_q[31:24];
    endcase
    // Halfword loads ignore alu[0]; alignment is the MEM stage's concern.
    sel_half = alu_q[1] ? mo_q[31:16] : mo_q[15:0];

    load_data = mo_q;
    case (ltype_q)
      LT_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU:  load_data = {24'd0, sel_byte};
      LT_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      LT_LHU:  load_data = {16'd0, sel_half};
      LT_LW:   load_data = mo_q;
      default: load_data = mo_q;
    endcase
  end
`else
  assign load_data = mo_q;
`endif

  // Outputs come straight from the registers and are not gated by stall:
  // a stalled instruction simply repeats the same write.
  assign wb_valid = valid_q;
  assign we       = valid_q & wreg_q & (rn_q != 5'd0);
  assign rw       = rn_q;
  assign rd       = m2reg_q ? load_data : alu_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed-vector bench for mem_wb_stage. A behavioural model tracks what is
// in the WB slot and how many instructions have left it; a compare process
// checks every DUT output against that model on each falling edge. Literal
// expectations in the stimulus pin the model itself.
// Define WB_SUBWORD_LOAD_EN when building to exercise the sub-word load path.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk;
  logic        clrn;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic        m_wreg;
  logic        m_m2reg;
  logic [4:0]  m_rn;
  logic [31:0] m_alu;
  logic [31:0] m_mo;
  logic [2:0]  m_ltype;
  logic        wb_valid;
  logic        we;
  logic [4:0]  rw;
  logic [31:0] rd;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage dut (
    .clk      (clk),
    .clrn     (clrn),
    .stall    (stall),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_wreg   (m_wreg),
    .m_m2reg  (m_m2reg),
    .m_rn     (m_rn),
    .m_alu    (m_alu),
    .m_mo     (m_mo),
    .m_ltype  (m_ltype),
    .wb_valid (wb_valid),
    .we       (we),
    .rw       (rw),
    .rd       (rd),
    .retired  (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the instruction sitting in WB plus a retire tally.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          valid;
    bit          wreg;
    bit          m2reg;
    int          rn;
    bit [31:0]   alu;
    bit [31:0]   mo;
    int          ltype;
  } slot_t;

  slot_t     mdl;
  bit [31:0] mdl_retired;

  function automatic bit [31:0] model_load(slot_t s);
    int b[4];
    int off;
    int v;
    for (int i = 0; i < 4; i++) b[i] = int'((s.mo >> (8 * i)) & 32'hFF);
    off = int'(s.alu % 4);
`ifdef WB_SUBWORD_LOAD_EN
    case (s.ltype)
      1: begin v = b[off]; if (v >= 128) v -= 256; return 32'(v); end
      2: return 32'(b[off]);
      3, 4: begin
        v = b[(off / 2) * 2] + 256 * b[(off / 2) * 2 + 1];
        if (s.ltype == 3 && v >= 32768) v -= 65536;
        return 32'(v);
      end
      default: return s.mo;
    endcase
`else
    return s.mo;
`endif
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mdl = '{default: 0};
      mdl_retired = 32'd0;
    end else begin
      if (mdl.valid && (!stall || flush)) mdl_retired = mdl_retired + 32'd1;
      if (flush || !stall) begin
        mdl.valid = m_valid && !flush;
        mdl.wreg  = m_wreg;
        mdl.m2reg = m_m2reg;
        mdl.rn    = int'(m_rn);
        mdl.alu   = m_alu;
        mdl.mo    = m_mo;
        mdl.ltype = int'(m_ltype);
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && clrn) begin
      check("cmp_wb_valid", {31'd0, wb_valid}, {31'd0, mdl.valid});
      check("cmp_we", {31'd0, we},
            {31'd0, mdl.valid && mdl.wreg && mdl.rn != 0});
      check("cmp_rw", {27'd0, rw}, 32'(mdl.rn));
      check("cmp_rd", rd, mdl.m2reg ? model_load(mdl) : mdl.alu);
      check("cmp_retired", retired, mdl_retired);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic m2r,
                       input logic [4:0] rn, input logic [31:0] alu,
                       input logic [31:0] mo, input logic [2:0] lt);
    m_valid = v;
    m_wreg  = wr;
    m_m2reg = m2r;
    m_rn    = rn;
    m_alu   = alu;
    m_mo    = mo;
    m_ltype = lt;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0);
  endtask

  // Sub-word load vectors: {ltype, alu}, with the expected rd for each build.
  logic [2:0]  sw_lt  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] sw_alu [4] = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1002, 32'h0000_1000};
`ifdef WB_SUBWORD_LOAD_EN
  logic [31:0] sw_exp [4] = '{32'hFFFF_FF80, 32'h0000_00F1, 32'hFFFF_80F1, 32'h0000_7F22};
`else
  logic [31:0] sw_exp [4] = '{32'h80F1_7F22, 32'h80F1_7F22, 32'h80F1_7F22, 32'h80F1_7F22};
`endif

  initial begin
    clrn  = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    bubble();

    // Reset held: everything reads zero.
    #12;
    check("rst_we",       {31'd0, we}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_rw",       {27'd0, rw}, 32'd0);
    check("rst_rd",       rd, 32'd0);
    check("rst_retired",  retired, 32'd0);

    // Release mid-cycle.
    @(negedge clk);
    #2;
    clrn = 1'b1;
    cmp_en = 1'b1;
    step();

    // Basic ALU writeback to r9.
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h1234_5678, 32'hDEAD_BEEF, 3'd0);
    step();
    check("alu_we", {31'd0, we}, 32'd1);
    check("alu_rw", {27'd0, rw}, 32'd9);
    check("alu_rd", rd, 32'h1234_5678);
    check("alu_retired_before", retired, 32'd0);
    bubble();
    step();
    check("alu_retired_after", retired, 32'd1);
    check("bubble_we", {31'd0, we}, 32'd0);

    // Write to r0 is suppressed but still retires.
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_00AA, 32'd0, 3'd0);
    step();
    check("r0_we", {31'd0, we}, 32'd0);
    check("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
    bubble();
    step();
    check("r0_retired", retired, 32'd2);

    // Stall: A held for 3 cycles while B waits.
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'hAAAA_0001, 32'd0, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'hBBBB_0002, 32'd0, 3'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rw", {27'd0, rw}, 32'd3);
      check("stall_rd", rd, 32'hAAAA_0001);
      check("stall_we", {31'd0, we}, 32'd1);
    end
    check("stall_retired", retired, 32'd2);
    stall = 1'b0;
    step();
    check("unstall_rw", {27'd0, rw}, 32'd4);
    check("unstall_rd", rd, 32'hBBBB_0002);
    check("unstall_retired", retired, 32'd3);
    bubble();
    step();
    check("b_retired", retired, 32'd4);

    // Stall and flush together: flush wins, the leaving instruction counts.
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'hCCCC_0003, 32'd0, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd6, 32'hDDDD_0004, 32'd0, 3'd0);
    stall = 1'b1;
    flush = 1'b1;
    step();
    stall = 1'b0;
    flush = 1'b0;
    check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_we", {31'd0, we}, 32'd0);
    check("flush_retired", retired, 32'd5);

    // Bubble with wreg set never writes and never counts.
    drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h7777_7777, 32'd0, 3'd0);
    step();
    check("bub_we", {31'd0, we}, 32'd0);
    check("bub_wb_valid", {31'd0, wb_valid}, 32'd0);
    step();
    check("bub_retired", retired, 32'd5);

    // Memory writeback, sub-word selection.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd1, sw_alu[i], 32'h80F1_7F22, sw_lt[i]);
      step();
      check($sformatf("load_rd_%0d", i), rd, sw_exp[i]);
    end
    // Reserved load type behaves as LW.
    drive(1'b1, 1'b1, 1'b1, 5'd1, 32'h0000_1003, 32'h80F1_7F22, 3'd6);
    step();
    check("load_rd_rsvd", rd, 32'h80F1_7F22);
    bubble();
    step();
    check("load_retired", retired, 32'd10);

    // Reset mid-operation drops the in-flight instruction.
    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h8888_0008, 32'd0, 3'd0);
    step();
    bubble();
    #2;
    clrn = 1'b0;
    #1;
    check("midrst_we", {31'd0, we}, 32'd0);
    check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("midrst_retired", retired, 32'd0);
    @(negedge clk);
    #2;
    clrn = 1'b1;
    step();

    // Counter wrap: preload near the top, then retire one more.
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h2222_0002, 32'd0, 3'd0);
    step();
    bubble();
    force dut.retired_q = 32'hFFFF_FFFF;
    mdl_retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    check("wrap_preload", retired, 32'hFFFF_FFFF);
    step();
    check("wrap_retired", retired, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
